sme_pe_master: RTL and testbench

- Scheduler for the parallel string-matching engine; owns NUM_SLAVE pe_slave instances.
- Accepts one string/pattern job and splits the candidate start positions into contiguous ranges, one range per slave.
- Launches the slaves, collects their results and reports the lowest matching index.
- Sits between the top-level job interface and the slave array; all slaves share one registered string/pattern bus.

---
 rtl/sme_pkg.sv | 22 ++
 rtl/sme_range_split.sv | 42 ++++
 rtl/sme_pe_master.sv | 175 +++++++++++++++++
 tb/tb_sme_pe_master.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sme_pkg.sv
// sme_pkg: shared constants and one-hot state encodings for the string-matching engine.
// The master and the pe_slave instances both import this package.
package sme_pkg;

  localparam int BYTE           = 8;
  localparam int MAX_STRING     = 32;
  localparam int MAX_STR_ADD    = 5;
  localparam int MAX_PATTERN    = 8;
  localparam int MAX_PAT_ADD    = 3;
  localparam int NUM_SLAVE      = 4;
  localparam int SLV_ADD        = $clog2(NUM_SLAVE);
  localparam int TIMEOUT_CYCLES = 64;

  // One-hot states; PRE_ST is the dispatch cycle, COM_ST the collection phase
  typedef enum logic [3:0] {
    IDLE_ST = 4'b0001,
    PRE_ST  = 4'b0010,
    COM_ST  = 4'b0100,
    DONE_ST = 4'b1000
  } state_t;

endpackage

// File: rtl/sme_range_split.sv
// sme_range_split: splits the candidate start positions of a job into one
// contiguous ascending range per slave and flags jobs that cannot match.
module sme_range_split
  import sme_pkg::*;
(
  input  logic [MAX_STR_ADD:0]             str_len,
  input  logic [3:0]                       pat_len,
  output logic [NUM_SLAVE*MAX_STR_ADD-1:0] start_idx,
  output logic [NUM_SLAVE*MAX_STR_ADD-1:0] end_idx,
  output logic [NUM_SLAVE-1:0]             launched_mask,
  output logic                             degenerate
);

  logic [MAX_STR_ADD:0]   num_pos;
  logic [MAX_STR_ADD+1:0] chunk;
  logic [MAX_STR_ADD+1:0] last_pos;
  logic [MAX_STR_ADD+1:0] range_start;
  logic [MAX_STR_ADD+1:0] range_end;

  // Compute candidate count, per-slave chunk size and each slave's range
  always_comb begin
    range_start   = '0;
    range_end     = '0;
    start_idx     = '0;
    end_idx       = '0;
    launched_mask = '0;
    degenerate    = (pat_len == 4'd0) || (pat_len > 4'(MAX_PATTERN)) ||
                    ({2'b00, pat_len} > str_len);
    num_pos       = str_len - {2'b00, pat_len} + 6'd1;
    chunk         = ({1'b0, num_pos} + 7'(NUM_SLAVE - 1)) >> SLV_ADD;
    last_pos      = {1'b0, num_pos} - 7'd1;
    for (int i = 0; i < NUM_SLAVE; i++) begin
      range_start = 7'(i) * chunk;
      range_end   = range_start + chunk - 7'd1;
      if (range_end > last_pos) range_end = last_pos;
      start_idx[i*MAX_STR_ADD +: MAX_STR_ADD] = range_start[MAX_STR_ADD-1:0];
      end_idx[i*MAX_STR_ADD +: MAX_STR_ADD]   = range_end[MAX_STR_ADD-1:0];
      launched_mask[i] = !degenerate && (range_start <= last_pos);
    end
  end

endmodule

// File: rtl/sme_pe_master.sv
// sme_pe_master: job scheduler for the parallel string-matching engine.
// Accepts one job, launches the slaves over disjoint ranges, collects their
// results and reports the lowest matching index.
// Optional watchdog enabled by defining SME_TIMEOUT_EN.
module sme_pe_master
  import sme_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic [MAX_STRING*BYTE-1:0]       str_input,
  input  logic [MAX_STR_ADD:0]             str_len,
  input  logic [MAX_PATTERN*BYTE-1:0]      pat_input,
  input  logic [3:0]                       pat_len,
  input  logic                             input_valid,
  output logic                             ready,
  output logic [MAX_STRING*BYTE-1:0]       slv_str,
  output logic [MAX_PATTERN*BYTE-1:0]      slv_pat,
  output logic [NUM_SLAVE-1:0]             slv_input_valid,
  output logic [NUM_SLAVE*MAX_STR_ADD-1:0] slv_start_idx,
  output logic [NUM_SLAVE*MAX_STR_ADD-1:0] slv_end_idx,
  input  logic [NUM_SLAVE-1:0]             slv_output_valid,
  input  logic [NUM_SLAVE-1:0]             slv_match,
  input  logic [NUM_SLAVE*MAX_STR_ADD-1:0] slv_match_idx,
  output logic                             output_valid,
  output logic                             match,
  output logic [MAX_STR_ADD-1:0]           match_idx,
  output logic                             timeout
);

  state_t                           state;
  logic [NUM_SLAVE*MAX_STR_ADD-1:0] split_start;
  logic [NUM_SLAVE*MAX_STR_ADD-1:0] split_end;
  logic [NUM_SLAVE-1:0]             split_mask;
  logic                             split_degenerate;

  logic [NUM_SLAVE-1:0]             launched_mask;
  logic [NUM_SLAVE-1:0]             done_mask;
  logic [NUM_SLAVE-1:0]             hit_flags;
  logic [NUM_SLAVE*MAX_STR_ADD-1:0] hit_idx;

  logic [NUM_SLAVE-1:0]             new_done;
  logic [NUM_SLAVE-1:0]             next_done;
  logic [NUM_SLAVE-1:0]             next_flags;
  logic [NUM_SLAVE*MAX_STR_ADD-1:0] next_idx;
  logic                             sel_match;
  logic [MAX_STR_ADD-1:0]           sel_idx;
  logic                             wdog_expired;

  sme_range_split u_split (
    .str_len       (str_len),
    .pat_len       (pat_len),
    .start_idx     (split_start),
    .end_idx       (split_end),
    .launched_mask (split_mask),
    .degenerate    (split_degenerate)
  );

  // Merge this cycle's first-time completions into the latched results and pick the lowest matching slave
  always_comb begin
    new_done   = slv_output_valid & launched_mask & ~done_mask;
    next_done  = done_mask | new_done;
    next_flags = hit_flags;
    next_idx   = hit_idx;
    for (int i = 0; i < NUM_SLAVE; i++) begin
      if (new_done[i]) begin
        next_flags[i] = slv_match[i];
        next_idx[i*MAX_STR_ADD +: MAX_STR_ADD] = slv_match_idx[i*MAX_STR_ADD +: MAX_STR_ADD];
      end
    end
    sel_match = |next_flags;
    sel_idx   = '0;
    for (int i = NUM_SLAVE - 1; i >= 0; i--) begin
      if (next_flags[i]) sel_idx = next_idx[i*MAX_STR_ADD +: MAX_STR_ADD];
    end
  end

`ifdef SME_TIMEOUT_EN
  logic [7:0] wdog;

  assign wdog_expired = (wdog == 8'(TIMEOUT_CYCLES - 1));

  // Watchdog: cleared while dispatching, counts every collection cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog <= '0;
    end else if (state == PRE_ST) begin
      wdog <= '0;
    end else if (state == COM_ST) begin
      wdog <= wdog + 8'd1;
    end
  end
`else
  assign wdog_expired = 1'b0;
`endif

  // Main scheduler FSM with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE_ST;
      ready           <= 1'b1;
      slv_str         <= '0;
      slv_pat         <= '0;
      slv_input_valid <= '0;
      slv_start_idx   <= '0;
      slv_end_idx     <= '0;
      launched_mask   <= '0;
      done_mask       <= '0;
      hit_flags       <= '0;
      hit_idx         <= '0;
      output_valid    <= 1'b0;
      match           <= 1'b0;
      match_idx       <= '0;
      timeout         <= 1'b0;
    end else begin
      case (state)
        IDLE_ST: begin
          if (input_valid) begin
            ready         <= 1'b0;
            slv_str       <= str_input;
            slv_pat       <= pat_input;
            slv_start_idx <= split_start;
            slv_end_idx   <= split_end;
            launched_mask <= split_mask;
            done_mask     <= '0;
            hit_flags     <= '0;
            hit_idx       <= '0;
            if (split_degenerate) begin
              state        <= DONE_ST;
              output_valid <= 1'b1;
              match        <= 1'b0;
              match_idx    <= '0;
            end else begin
              state           <= PRE_ST;
              slv_input_valid <= split_mask;
            end
          end
        end
        PRE_ST: begin
          slv_input_valid <= '0;
          state           <= COM_ST;
        end
        COM_ST: begin
          done_mask <= next_done;
          hit_flags <= next_flags;
          hit_idx   <= next_idx;
          if (next_done == launched_mask) begin
            state        <= DONE_ST;
            output_valid <= 1'b1;
            match        <= sel_match;
            match_idx    <= sel_idx;
          end else if (wdog_expired) begin
            state        <= DONE_ST;
            output_valid <= 1'b1;
            match        <= 1'b0;
            match_idx    <= '0;
            timeout      <= 1'b1;
          end
        end
        DONE_ST: begin
          state        <= IDLE_ST;
          ready        <= 1'b1;
          output_valid <= 1'b0;
          match        <= 1'b0;
          match_idx    <= '0;
          timeout      <= 1'b0;
        end
        default: begin
          state <= IDLE_ST;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sme_pe_master.sv
// tb_sme_pe_master: directed self-checking bench for sme_pe_master.
// The bench plays the role of the slave array; expected ranges and results are hand-computed.
// Define SME_TIMEOUT_EN to also exercise the watchdog.
module tb_sme_pe_master;
  import sme_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] str_input;
  logic [5:0]   str_len;
  logic [63:0]  pat_input;
  logic [3:0]   pat_len;
  logic         input_valid;
  logic         ready;
  logic [255:0] slv_str;
  logic [63:0]  slv_pat;
  logic [3:0]   slv_input_valid;
  logic [19:0]  slv_start_idx;
  logic [19:0]  slv_end_idx;
  logic [3:0]   slv_output_valid;
  logic [3:0]   slv_match;
  logic [19:0]  slv_match_idx;
  logic         output_valid;
  logic         match;
  logic [4:0]   match_idx;
  logic         timeout;

  int check_count = 0;
  int pass_count  = 0;

  logic [255:0] str_a;
  logic [63:0]  pat_a;

  always #5 clk = ~clk;

  sme_pe_master dut (
    .clk              (clk),
    .reset            (reset),
    .str_input        (str_input),
    .str_len          (str_len),
    .pat_input        (pat_input),
    .pat_len          (pat_len),
    .input_valid      (input_valid),
    .ready            (ready),
    .slv_str          (slv_str),
    .slv_pat          (slv_pat),
    .slv_input_valid  (slv_input_valid),
    .slv_start_idx    (slv_start_idx),
    .slv_end_idx      (slv_end_idx),
    .slv_output_valid (slv_output_valid),
    .slv_match        (slv_match),
    .slv_match_idx    (slv_match_idx),
    .output_valid     (output_valid),
    .match            (match),
    .match_idx        (match_idx),
    .timeout          (timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic submit(input logic [255:0] s, input logic [5:0] sl,
                        input logic [63:0] p, input logic [3:0] pl);
    str_input   = s;
    str_len     = sl;
    pat_input   = p;
    pat_len     = pl;
    input_valid = 1'b1;
    tick();
    input_valid = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] v, input logic [3:0] m, input logic [19:0] idx);
    slv_output_valid = v;
    slv_match        = m;
    slv_match_idx    = idx;
    tick();
    slv_output_valid = '0;
    slv_match        = '0;
    slv_match_idx    = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    check_count++; if (ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", ready); else pass_count++;
    check_count++; if (output_valid !== 1'b0) $display("[TB] FAIL reset_ov: got %b expected 0", output_valid); else pass_count++;
    check_count++; if (slv_input_valid !== 4'b0000) $display("[TB] FAIL reset_slv_iv: got %b expected 0000", slv_input_valid); else pass_count++;
    check_count++; if ({match, match_idx, timeout} !== 7'd0) $display("[TB] FAIL reset_result: got %b expected 0", {match, match_idx, timeout}); else pass_count++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_match();
    submit(str_a, 6'd32, pat_a, 4'd4);
    check_count++; if (slv_input_valid !== 4'b1111) $display("[TB] FAIL single_launch: got %b expected 1111", slv_input_valid); else pass_count++;
    check_count++; if (slv_start_idx !== {5'd24, 5'd16, 5'd8, 5'd0}) $display("[TB] FAIL single_start: got %h expected %h", slv_start_idx, {5'd24, 5'd16, 5'd8, 5'd0}); else pass_count++;
    check_count++; if (slv_end_idx !== {5'd28, 5'd23, 5'd15, 5'd7}) $display("[TB] FAIL single_end: got %h expected %h", slv_end_idx, {5'd28, 5'd23, 5'd15, 5'd7}); else pass_count++;
    check_count++; if (slv_str !== str_a || slv_pat !== pat_a) $display("[TB] FAIL single_bus: got %h/%h expected %h/%h", slv_str, slv_pat, str_a, pat_a); else pass_count++;
    check_count++; if (ready !== 1'b0) $display("[TB] FAIL single_busy: got %b expected 0", ready); else pass_count++;
    tick();
    check_count++; if (slv_input_valid !== 4'b0000) $display("[TB] FAIL single_launch_pulse: got %b expected 0000", slv_input_valid); else pass_count++;
    pulse(4'b0001, 4'b0000, 20'd0);
    check_count++; if (output_valid !== 1'b0) $display("[TB] FAIL single_early1: got %b expected 0", output_valid); else pass_count++;
    pulse(4'b0110, 4'b0100, {5'd0, 5'd20, 5'd0, 5'd0});
    check_count++; if (output_valid !== 1'b0) $display("[TB] FAIL single_early2: got %b expected 0", output_valid); else pass_count++;
    pulse(4'b0001, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd5});
    check_count++; if (output_valid !== 1'b0) $display("[TB] FAIL single_repeat: got %b expected 0", output_valid); else pass_count++;
    pulse(4'b1000, 4'b0000, 20'd0);
    check_count++; if (output_valid !== 1'b1) $display("[TB] FAIL single_ov: got %b expected 1", output_valid); else pass_count++;
    check_count++; if (match !== 1'b1 || match_idx !== 5'd20) $display("[TB] FAIL single_result: got %b/%0d expected 1/20", match, match_idx); else pass_count++;
    tick();
    check_count++; if (output_valid !== 1'b0 || ready !== 1'b1) $display("[TB] FAIL single_after: got ov=%b ready=%b expected 0/1", output_valid, ready); else pass_count++;
  endtask

  task automatic test_lowest_wins();
    submit(str_a, 6'd32, pat_a, 4'd4);
    tick();
    pulse(4'b1110, 4'b1000, {5'd25, 5'd0, 5'd0, 5'd0});
    repeat (4) tick();
    check_count++; if (output_valid !== 1'b0) $display("[TB] FAIL lowest_early: got %b expected 0", output_valid); else pass_count++;
    pulse(4'b0001, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd3});
    check_count++; if (output_valid !== 1'b1 || match !== 1'b1 || match_idx !== 5'd3) $display("[TB] FAIL lowest_result: got %b/%b/%0d expected 1/1/3", output_valid, match, match_idx); else pass_count++;
    tick();
  endtask

  task automatic test_short_string();
    submit(str_a, 6'd5, pat_a, 4'd4);
    check_count++; if (slv_input_valid !== 4'b0011) $display("[TB] FAIL short_launch: got %b expected 0011", slv_input_valid); else pass_count++;
    check_count++; if (slv_start_idx[9:0] !== {5'd1, 5'd0} || slv_end_idx[9:0] !== {5'd1, 5'd0}) $display("[TB] FAIL short_ranges: got %h/%h expected 020/020", slv_start_idx[9:0], slv_end_idx[9:0]); else pass_count++;
    tick();
    pulse(4'b1100, 4'b1100, {5'd3, 5'd2, 5'd0, 5'd0});
    check_count++; if (output_valid !== 1'b0) $display("[TB] FAIL short_spurious: got %b expected 0", output_valid); else pass_count++;
    pulse(4'b0011, 4'b0000, 20'd0);
    check_count++; if (output_valid !== 1'b1 || match !== 1'b0 || match_idx !== 5'd0) $display("[TB] FAIL short_result: got %b/%b/%0d expected 1/0/0", output_valid, match, match_idx); else pass_count++;
    tick();
  endtask

  task automatic test_degenerate();
    submit(str_a, 6'd32, pat_a, 4'd9);
    check_count++; if (output_valid !== 1'b1 || match !== 1'b0 || slv_input_valid !== 4'b0000) $display("[TB] FAIL degen9: got %b/%b/%b expected 1/0/0000", output_valid, match, slv_input_valid); else pass_count++;
    tick();
    check_count++; if (output_valid !== 1'b0 || ready !== 1'b1 || slv_input_valid !== 4'b0000) $display("[TB] FAIL degen9_after: got %b/%b/%b expected 0/1/0000", output_valid, ready, slv_input_valid); else pass_count++;
    submit(str_a, 6'd5, pat_a, 4'd6);
    check_count++; if (output_valid !== 1'b1 || match !== 1'b0 || slv_input_valid !== 4'b0000) $display("[TB] FAIL degen6: got %b/%b/%b expected 1/0/0000", output_valid, match, slv_input_valid); else pass_count++;
    tick();
    check_count++; if (output_valid !== 1'b0 || ready !== 1'b1 || slv_input_valid !== 4'b0000) $display("[TB] FAIL degen6_after: got %b/%b/%b expected 0/1/0000", output_valid, ready, slv_input_valid); else pass_count++;
  endtask

  task automatic test_reset_in_wait();
    submit(str_a, 6'd32, pat_a, 4'd4);
    tick();
    pulse(4'b0001, 4'b0000, 20'd0);
    reset = 1'b0;
    #1;
    check_count++; if (ready !== 1'b1 || slv_start_idx !== 20'd0 || slv_str !== 256'd0 || output_valid !== 1'b0) $display("[TB] FAIL rst_wait: got ready=%b start=%h ov=%b expected 1/0/0", ready, slv_start_idx, output_valid); else pass_count++;
    tick();
    reset = 1'b1;
    pulse(4'b1111, 4'b1111, {5'd9, 5'd6, 5'd3, 5'd1});
    check_count++; if (output_valid !== 1'b0 || ready !== 1'b1) $display("[TB] FAIL rst_stale: got ov=%b ready=%b expected 0/1", output_valid, ready); else pass_count++;
    submit(str_a, 6'd12, pat_a, 4'd3);
    check_count++; if (slv_start_idx !== {5'd9, 5'd6, 5'd3, 5'd0} || slv_end_idx !== {5'd9, 5'd8, 5'd5, 5'd2}) $display("[TB] FAIL rst_new_ranges: got %h/%h expected %h/%h", slv_start_idx, slv_end_idx, {5'd9, 5'd6, 5'd3, 5'd0}, {5'd9, 5'd8, 5'd5, 5'd2}); else pass_count++;
    tick();
    pulse(4'b1111, 4'b1100, {5'd9, 5'd7, 5'd0, 5'd0});
    check_count++; if (output_valid !== 1'b1 || match !== 1'b1 || match_idx !== 5'd7) $display("[TB] FAIL rst_new_result: got %b/%b/%0d expected 1/1/7", output_valid, match, match_idx); else pass_count++;
  endtask

  task automatic test_back_to_back();
    str_input   = str_a;
    str_len     = 6'd8;
    pat_input   = pat_a;
    pat_len     = 4'd8;
    input_valid = 1'b1;
    tick();
    check_count++; if (ready !== 1'b1 || slv_input_valid !== 4'b0000) $display("[TB] FAIL b2b_not_in_done: got ready=%b iv=%b expected 1/0000", ready, slv_input_valid); else pass_count++;
    tick();
    input_valid = 1'b0;
    check_count++; if (slv_input_valid !== 4'b0001 || slv_start_idx[4:0] !== 5'd0 || slv_end_idx[4:0] !== 5'd0) $display("[TB] FAIL b2b_launch: got iv=%b expected 0001", slv_input_valid); else pass_count++;
    tick();
    pulse(4'b0001, 4'b0001, 20'd0);
    check_count++; if (output_valid !== 1'b1 || match !== 1'b1 || match_idx !== 5'd0) $display("[TB] FAIL b2b_result: got %b/%b/%0d expected 1/1/0", output_valid, match, match_idx); else pass_count++;
    tick();
  endtask

`ifdef SME_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    submit(str_a, 6'd32, pat_a, 4'd4);
    tick();
    pulse(4'b1101, 4'b0000, 20'd0);
    k = 1;
    while (output_valid !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    check_count++; if (k !== 64) $display("[TB] FAIL timeout_latency: got %0d expected 64", k); else pass_count++;
    check_count++; if (timeout !== 1'b1 || match !== 1'b0) $display("[TB] FAIL timeout_flags: got %b/%b expected 1/0", timeout, match); else pass_count++;
    tick();
  endtask
`endif

  initial begin
    input_valid      = 1'b0;
    str_input        = '0;
    str_len          = '0;
    pat_input        = '0;
    pat_len          = '0;
    slv_output_valid = '0;
    slv_match        = '0;
    slv_match_idx    = '0;
    for (int i = 0; i < 32; i++) str_a[i*8 +: 8] = 8'h41 + 8'(i);
    pat_a = 64'h0000_0000_5857_5655;
    test_reset();
    test_single_match();
    test_lowest_wins();
    test_short_string();
    test_degenerate();
    test_reset_in_wait();
    test_back_to_back();
`ifdef SME_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
